aes_encrypt_core: RTL and testbench



---
 rtl/aes_encrypt_core.sv | 130 +++++++++++++
 tb/tb_aes_encrypt_core.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/192/256 forward cipher: one round per clock over a precomputed
// round-key schedule, with a start/busy/done handshake and a registered result.
module aes_encrypt_core #(
  parameter int KEY_SIZE = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [127:0]                    plaintext,
  input  logic [128*(KEY_SIZE/32+7)-1:0]  round_keys,
  input  logic                            keys_valid,
  output logic [127:0]                    ciphertext,
  output logic                            busy,
  output logic                            done
);
  localparam int         NR   = KEY_SIZE / 32 + 6;
  localparam logic [3:0] LAST = 4'(NR);

  typedef enum logic {IDLE, ROUND} fsm_t;

  fsm_t         r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_cnt;
  logic [127:0] w_rk;
  logic [127:0] w_sub_shift;
  logic [127:0] w_mixed;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // S-box from its definition: inverse a^254 in GF(2^8) (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] p;
    t = gmul(a, a);
    p = t;
    for (int i = 0; i < 6; i++) begin
      t = gmul(t, t);
      p = gmul(p, t);
    end
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  // Byte n sits at [127-8n -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  // The counter rests at 0 in IDLE, so the same select also supplies rk[0] at accept.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_rk = '0;
    for (int r = 0; r <= NR; r++)
      if (r_cnt == 4'(r)) w_rk = round_keys[128*(NR-r) +: 128];
    w_sub_shift = sub_shift(r_state);
    w_mixed     = mix_columns(w_sub_shift);
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm      <= IDLE;
      r_state    <= '0;
      r_cnt      <= '0;
      ciphertext <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (start && keys_valid) begin
            r_state <= plaintext ^ w_rk;
            r_cnt   <= 4'd1;
            busy    <= 1'b1;
            r_fsm   <= ROUND;
          end
        end
        ROUND: begin
          if (r_cnt == LAST) begin
            ciphertext <= w_sub_shift ^ w_rk;
            done       <= 1'b1;
            busy       <= 1'b0;
            r_cnt      <= '0;
            r_fsm      <= IDLE;
          end else begin
            r_state <= w_mixed ^ w_rk;
            r_cnt   <= r_cnt + 4'd1;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_encrypt_core.sv
// Bench for aes_encrypt_core: 128/192/256-bit instances share the handshake inputs and are
// checked against FIPS-197 vectors and a byte-level reference cipher with its own key expansion.
`timescale 1ns/1ps
module tb_aes_encrypt_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start, keys_valid;
  logic [127:0]      pt;
  logic [1407:0]     rk_bus0;
  logic [1663:0]     rk_bus1;
  logic [1919:0]     rk_bus2;
  logic [2:0][127:0] ct_v;
  logic [2:0]        busy_v, done_v;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_C   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_encrypt_core #(.KEY_SIZE(128)) dut128 (
    .clk(clk), .reset(reset), .start(start), .plaintext(pt), .round_keys(rk_bus0),
    .keys_valid(keys_valid), .ciphertext(ct_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  aes_encrypt_core #(.KEY_SIZE(192)) dut192 (
    .clk(clk), .reset(reset), .start(start), .plaintext(pt), .round_keys(rk_bus1),
    .keys_valid(keys_valid), .ciphertext(ct_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  aes_encrypt_core #(.KEY_SIZE(256)) dut256 (
    .clk(clk), .reset(reset), .start(start), .plaintext(pt), .round_keys(rk_bus2),
    .keys_valid(keys_valid), .ciphertext(ct_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // ---------------- reference model ----------------
  logic [7:0]   sbox_t [256];
  logic [127:0] rk_m   [3][15];

  function automatic int nr_of(input int k);
    return 10 + 2 * k;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] ffm(input logic [7:0] a, input int coef);
    case (coef)
      2:       return xt(a);
      3:       return xt(a) ^ a;
      default: return a;
    endcase
  endfunction

  // Walks the multiplicative group with generator 3 and its inverse in lockstep.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic load_keys(input int k, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, nr;
    nk   = 4 + 2 * k;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      rk_m[k][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      case (k)
        0:       rk_bus0[128*(nr-r) +: 128] = rk_m[k][r];
        1:       rk_bus1[128*(nr-r) +: 128] = rk_m[k][r];
        default: rk_bus2[128*(nr-r) +: 128] = rk_m[k][r];
      endcase
    end
  endtask

  function automatic logic [127:0] ref_enc(input int k, input logic [127:0] p);
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] rk, o;
    int coef [4];
    int nr;
    coef = '{2, 3, 1, 1};
    nr   = nr_of(k);
    rk   = rk_m[k][0];
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) u[r+4*c] = s[r+4*((c+r)%4)];
      s = u;
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            u[r+4*c] = 8'h00;
            for (int j = 0; j < 4; j++) u[r+4*c] = u[r+4*c] ^ ffm(s[j+4*c], coef[(j-r+4)%4]);
          end
        s = u;
      end
      rk = rk_m[k][rnd];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- scenario tasks ----------------
  // Accept one block on all three cores, then watch 17 cycles of busy/done/ciphertext.
  task automatic run_block(input logic [127:0] p, input logic [2:0][127:0] exp,
                           input bit poke, input string tag);
    int done_at [3];
    int done_cnt [3];
    int busy_cnt [3];
    logic [127:0] got [3];
    int overlap;
    overlap = 0;
    for (int k = 0; k < 3; k++) begin
      done_at[k] = -1; done_cnt[k] = 0; busy_cnt[k] = 0; got[k] = '0;
    end
    @(negedge clk);
    pt = p; start = 1'b1; keys_valid = 1'b1;
    for (int m = 0; m < 17; m++) begin
      @(negedge clk);
      start = (poke && m < 7) ? 1'b1 : 1'b0;
      if (poke) pt = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 3; k++) begin
        if (busy_v[k]) busy_cnt[k]++;
        if (busy_v[k] && done_v[k]) overlap++;
        if (done_v[k]) begin
          done_cnt[k]++;
          if (done_at[k] < 0) begin done_at[k] = m; got[k] = ct_v[k]; end
        end
      end
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (got[k] !== exp[k]) begin
        n_bad++; $display("FAIL %s[%0d] ciphertext: got %h want %h", tag, k, got[k], exp[k]);
      end
      n_cmp++;
      if (done_at[k] !== nr_of(k)) begin
        n_bad++; $display("FAIL %s[%0d] latency: got %0d want %0d", tag, k, done_at[k], nr_of(k));
      end
      n_cmp++;
      if (done_cnt[k] !== 1) begin
        n_bad++; $display("FAIL %s[%0d] done pulses: got %0d want 1", tag, k, done_cnt[k]);
      end
      n_cmp++;
      if (busy_cnt[k] !== nr_of(k)) begin
        n_bad++; $display("FAIL %s[%0d] busy cycles: got %0d want %0d", tag, k, busy_cnt[k], nr_of(k));
      end
    end
    n_cmp++;
    if (overlap !== 0) begin
      n_bad++; $display("FAIL %s busy_done_overlap: got %0d want 0", tag, overlap);
    end
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    if (ct_v !== '0 || busy_v !== 3'b000 || done_v !== 3'b000) begin
      n_bad++;
      $display("FAIL %s outputs: got ct=%h busy=%b done=%b want all zero", tag, ct_v, busy_v, done_v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; keys_valid = 1'b0; pt = '0;
    rk_bus0 = '0; rk_bus1 = '0; rk_bus2 = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
  endtask

  task automatic test_fips_c();
    logic [2:0][127:0] e;
    for (int k = 0; k < 3; k++) load_keys(k, KEY_C);
    e[0] = CT_C128; e[1] = CT_C192; e[2] = CT_C256;
    run_block(PT_C, e, 1'b0, "fips_c");
  endtask

  task automatic test_fips_b();
    logic [2:0][127:0] e;
    load_keys(0, KEY_B);
    e[0] = CT_B; e[1] = ref_enc(1, PT_B); e[2] = ref_enc(2, PT_B);
    run_block(PT_B, e, 1'b0, "fips_b");
  endtask

  task automatic test_random();
    logic [2:0][127:0] e;
    logic [127:0] p;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 3; k++)
        load_keys(k, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      p = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 3; k++) e[k] = ref_enc(k, p);
      run_block(p, e, 1'b0, "random");
    end
  endtask

  task automatic test_keys_invalid();
    int seen_busy, seen_done;
    seen_busy = 0; seen_done = 0;
    @(negedge clk);
    keys_valid = 1'b0; start = 1'b1;
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      if (m == 3) start = 1'b0;
      if (busy_v != 3'b000) seen_busy++;
      if (done_v != 3'b000) seen_done++;
    end
    keys_valid = 1'b1;
    n_cmp++;
    if (seen_busy !== 0) begin
      n_bad++; $display("FAIL keys_invalid busy cycles: got %0d want 0", seen_busy);
    end
    n_cmp++;
    if (seen_done !== 0) begin
      n_bad++; $display("FAIL keys_invalid done cycles: got %0d want 0", seen_done);
    end
  endtask

  task automatic test_start_while_busy();
    logic [2:0][127:0] e;
    logic [127:0] p;
    p = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 3; k++) e[k] = ref_enc(k, p);
    run_block(p, e, 1'b1, "start_busy");
  endtask

  task automatic test_back_to_back();
    int t1, t2, held_bad;
    t1 = -1; t2 = -1; held_bad = 0;
    load_keys(0, KEY_B);
    @(negedge clk);
    pt = PT_B; start = 1'b1; keys_valid = 1'b1;
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_v[0]) begin t1 = m; break; end
    end
    n_cmp++;
    if (t1 !== 10 || ct_v[0] !== CT_B) begin
      n_bad++; $display("FAIL b2b first: got lat=%0d ct=%h want lat=10 ct=%h", t1, ct_v[0], CT_B);
    end
    load_keys(0, KEY_C);
    pt = PT_C; start = 1'b1;
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_v[0]) begin t2 = m; break; end
      if (ct_v[0] !== CT_B) held_bad++;
    end
    n_cmp++;
    if (t2 + 1 !== 11) begin
      n_bad++; $display("FAIL b2b done spacing: got %0d want 11", t2 + 1);
    end
    n_cmp++;
    if (ct_v[0] !== CT_C128) begin
      n_bad++; $display("FAIL b2b second ct: got %h want %h", ct_v[0], CT_C128);
    end
    n_cmp++;
    if (held_bad !== 0) begin
      n_bad++; $display("FAIL b2b previous ct held: got %0d changes want 0", held_bad);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_held_start();
    logic [127:0] p;
    logic [127:0] e [3];
    int cnt [3];
    int first [3];
    int last [3];
    int gap_bad [3];
    int ct_bad [3];
    p = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 3; k++) begin
      e[k] = ref_enc(k, p); cnt[k] = 0; first[k] = -1; last[k] = -1; gap_bad[k] = 0; ct_bad[k] = 0;
    end
    @(negedge clk);
    pt = p; start = 1'b1; keys_valid = 1'b1;
    for (int m = 0; m < 75; m++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (done_v[k]) begin
          if (cnt[k] == 0) first[k] = m;
          else if (m - last[k] != nr_of(k) + 1) gap_bad[k]++;
          last[k] = m;
          cnt[k]++;
          if (ct_v[k] !== e[k]) ct_bad[k]++;
        end
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (first[k] !== nr_of(k)) begin
        n_bad++; $display("FAIL held[%0d] first done: got %0d want %0d", k, first[k], nr_of(k));
      end
      n_cmp++;
      if (gap_bad[k] !== 0) begin
        n_bad++; $display("FAIL held[%0d] bad spacings: got %0d want 0", k, gap_bad[k]);
      end
      n_cmp++;
      if (cnt[k] !== 75 / (nr_of(k) + 1)) begin
        n_bad++; $display("FAIL held[%0d] done count: got %0d want %0d", k, cnt[k], 75 / (nr_of(k) + 1));
      end
      n_cmp++;
      if (ct_bad[k] !== 0) begin
        n_bad++; $display("FAIL held[%0d] wrong ciphertexts: got %0d want 0", k, ct_bad[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0][127:0] e;
    int stray;
    stray = 0;
    for (int k = 0; k < 3; k++) load_keys(k, KEY_C);
    @(negedge clk);
    pt = PT_C; start = 1'b1; keys_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("reset_mid");
    reset = 1'b0;
    for (int m = 0; m < 20; m++) begin
      @(negedge clk);
      if (done_v != 3'b000 || busy_v != 3'b000) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin
      n_bad++; $display("FAIL reset_mid activity after abort: got %0d cycles want 0", stray);
    end
    e[0] = CT_C128; e[1] = CT_C192; e[2] = CT_C256;
    run_block(PT_C, e, 1'b0, "post_reset");
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_c();
    test_fips_b();
    test_random();
    test_keys_invalid();
    test_start_while_busy();
    test_back_to_back();
    test_held_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
